// File: rtl/serial_axi_pkg.sv
// ============================================================================
// Package : serial_axi_pkg -- opcodes, AXI constants and FSM states for the
//           UART-to-AXI command bridge.                          Revision 1.0
// ============================================================================
`default_nettype none

package serial_axi_pkg;

    localparam logic [7:0] OP_WRITE   = 8'h57;
    localparam logic [7:0] OP_READ    = 8'h52;
    localparam logic [7:0] ACK_BYTE   = 8'h4B;
    localparam logic [2:0] AXSIZE_16B = 3'b100;
    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_AW    = 3'd3,
        ST_B     = 3'd4,
        ST_AR    = 3'd5,
        ST_R     = 3'd6,
        ST_RESP  = 3'd7
    } bridge_state_t;

endpackage

`default_nettype wire

// File: rtl/serial_axi_resp_ser.sv
// ============================================================================
// Module : serial_axi_resp_ser -- loads up to NBYTES+1 response bytes and
//          shifts them out on a valid/ready byte stream.         Revision 1.0
// ============================================================================
`default_nettype none

module serial_axi_resp_ser #(
    parameter int NBYTES = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic [(NBYTES+1)*8-1:0]       load_data,
    input  logic [$clog2(NBYTES+2)-1:0]   load_len,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic                          done
);

    localparam int LW = $clog2(NBYTES + 2);

    logic [(NBYTES+1)*8-1:0] r_buf;
    logic [LW-1:0]           r_left;
    logic                    r_valid;
    logic                    w_fire;

    assign w_fire = r_valid && tx_ready;

    // Byte 0 of the buffer is always the byte on the wire, so tx_data only
    // moves on a handshake edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf   <= '0;
            r_left  <= '0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_buf   <= load_data;
            r_left  <= load_len;
            r_valid <= 1'b1;
        end else if (w_fire) begin
            r_buf  <= r_buf >> 8;
            r_left <= r_left - LW'(1);
            if (r_left == LW'(1)) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign tx_data  = r_buf[7:0];
    assign tx_valid = r_valid;
    assign done     = w_fire && (r_left == LW'(1));

endmodule

`default_nettype wire

// File: rtl/serial_axi_bridge.sv
// ============================================================================
// Module : serial_axi_bridge -- parses UART command frames into single-beat
//          AXI4 transactions. Option: SERIAL_AXI_BRIDGE_STATUS_EN. Rev 1.0
// ============================================================================
`default_nettype none

module serial_axi_bridge
    import serial_axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    clk,
    input  logic                    sys_rst,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [ID_WIDTH-1:0]     s_axi_awid,
    output logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    output logic [7:0]              s_axi_awlen,
    output logic [2:0]              s_axi_awsize,
    output logic [1:0]              s_axi_awburst,
    output logic                    s_axi_awlock,
    output logic [3:0]              s_axi_awcache,
    output logic [2:0]              s_axi_awprot,
    output logic [3:0]              s_axi_awqos,
    output logic                    s_axi_awvalid,
    input  logic                    s_axi_awready,
    output logic [DATA_WIDTH-1:0]   s_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    output logic                    s_axi_wlast,
    output logic                    s_axi_wvalid,
    input  logic                    s_axi_wready,
    output logic                    s_axi_bready,
    input  logic [ID_WIDTH-1:0]     s_axi_bid,
    input  logic [1:0]              s_axi_bresp,
    input  logic                    s_axi_bvalid,
    output logic [ID_WIDTH-1:0]     s_axi_arid,
    output logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    output logic [7:0]              s_axi_arlen,
    output logic [2:0]              s_axi_arsize,
    output logic [1:0]              s_axi_arburst,
    output logic                    s_axi_arlock,
    output logic [3:0]              s_axi_arcache,
    output logic [2:0]              s_axi_arprot,
    output logic [3:0]              s_axi_arqos,
    output logic                    s_axi_arvalid,
    input  logic                    s_axi_arready,
    output logic                    s_axi_rready,
    input  logic [ID_WIDTH-1:0]     s_axi_rid,
    input  logic [DATA_WIDTH-1:0]   s_axi_rdata,
    input  logic [1:0]              s_axi_rresp,
    input  logic                    s_axi_rlast,
    input  logic                    s_axi_rvalid
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int CW     = $clog2(NBYTES + 4);
    localparam int LW     = $clog2(NBYTES + 2);
    localparam int PW     = (NBYTES + 1) * 8;

    bridge_state_t         r_state;
    logic [CW-1:0]         r_cnt;
    logic                  r_is_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_arvalid;
    logic                  r_bready;
    logic                  r_rready;

    logic                  w_rx_fire;
    logic                  w_b_fire;
    logic                  w_r_fire;
    logic                  w_load;
    logic                  w_ser_done;
    logic [PW-1:0]         w_load_data;
    logic [LW-1:0]         w_load_len;
    logic                  w_unused;

    assign rx_ready  = (r_state == ST_IDLE) || (r_state == ST_ADDR) || (r_state == ST_WDATA);
    assign w_rx_fire = rx_valid && rx_ready;
    assign w_b_fire  = (r_state == ST_B) && r_bready && s_axi_bvalid;
    assign w_r_fire  = (r_state == ST_R) && r_rready && s_axi_rvalid;
    assign w_load    = w_b_fire || w_r_fire;

    // Response payload is captured straight into the serializer on the B/R
    // handshake; the optional status byte rides one position after the data.
    always_comb begin
        w_load_data = '0;
        w_load_len  = '0;
        if (r_state == ST_B) begin
            w_load_data[7:0] = ACK_BYTE;
`ifdef SERIAL_AXI_BRIDGE_STATUS_EN
            w_load_data[15:8] = {6'b0, s_axi_bresp};
            w_load_len        = LW'(2);
`else
            w_load_len        = LW'(1);
`endif
        end else begin
            w_load_data[DATA_WIDTH-1:0] = s_axi_rdata;
`ifdef SERIAL_AXI_BRIDGE_STATUS_EN
            w_load_data[PW-1:DATA_WIDTH] = {6'b0, s_axi_rresp};
            w_load_len                   = LW'(NBYTES + 1);
`else
            w_load_len                   = LW'(NBYTES);
`endif
        end
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_is_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_arvalid  <= 1'b0;
            r_bready   <= 1'b0;
            r_rready   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_rx_fire) begin
                    r_cnt      <= '0;
                    r_is_write <= (rx_data == OP_WRITE);
                    if ((rx_data == OP_WRITE) || (rx_data == OP_READ)) begin
                        r_state <= ST_ADDR;
                    end
                end
                // Shifting keeps only the low ADDR_WIDTH bits of the 32-bit value.
                ST_ADDR: if (w_rx_fire) begin
                    r_addr <= {r_addr[ADDR_WIDTH-9:0], rx_data};
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == CW'(3)) begin
                        r_cnt <= '0;
                        if (r_is_write) begin
                            r_state <= ST_WDATA;
                        end else begin
                            r_state   <= ST_AR;
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                ST_WDATA: if (w_rx_fire) begin
                    r_wdata <= {rx_data, r_wdata[DATA_WIDTH-1:8]};
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == CW'(NBYTES - 1)) begin
                        r_state   <= ST_AW;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                    end
                end
                ST_AW: begin
                    if (s_axi_awready) r_awvalid <= 1'b0;
                    if (s_axi_wready)  r_wvalid  <= 1'b0;
                    if ((!r_awvalid || s_axi_awready) && (!r_wvalid || s_axi_wready)) begin
                        r_state  <= ST_B;
                        r_bready <= 1'b1;
                    end
                end
                ST_B: if (w_b_fire) begin
                    r_bready <= 1'b0;
                    r_state  <= ST_RESP;
                end
                ST_AR: if (s_axi_arready) begin
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b1;
                    r_state   <= ST_R;
                end
                ST_R: if (w_r_fire) begin
                    r_rready <= 1'b0;
                    r_state  <= ST_RESP;
                end
                ST_RESP: if (w_ser_done) begin
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    serial_axi_resp_ser #(
        .NBYTES    (NBYTES)
    ) u_resp_ser (
        .clk       (clk),
        .rst       (sys_rst),
        .load      (w_load),
        .load_data (w_load_data),
        .load_len  (w_load_len),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .done      (w_ser_done)
    );

    assign s_axi_awid    = '0;
    assign s_axi_awaddr  = {r_addr[ADDR_WIDTH-1:4], 4'b0};
    assign s_axi_awlen   = 8'd0;
    assign s_axi_awsize  = AXSIZE_16B;
    assign s_axi_awburst = BURST_INCR;
    assign s_axi_awlock  = 1'b0;
    assign s_axi_awcache = 4'd0;
    assign s_axi_awprot  = 3'd0;
    assign s_axi_awqos   = 4'd0;
    assign s_axi_awvalid = r_awvalid;
    assign s_axi_wdata   = r_wdata;
    assign s_axi_wstrb   = '1;
    assign s_axi_wlast   = r_wvalid;
    assign s_axi_wvalid  = r_wvalid;
    assign s_axi_bready  = r_bready;
    assign s_axi_arid    = '0;
    assign s_axi_araddr  = {r_addr[ADDR_WIDTH-1:4], 4'b0};
    assign s_axi_arlen   = 8'd0;
    assign s_axi_arsize  = AXSIZE_16B;
    assign s_axi_arburst = BURST_INCR;
    assign s_axi_arlock  = 1'b0;
    assign s_axi_arcache = 4'd0;
    assign s_axi_arprot  = 3'd0;
    assign s_axi_arqos   = 4'd0;
    assign s_axi_arvalid = r_arvalid;
    assign s_axi_rready  = r_rready;

    assign w_unused = ^{s_axi_bid, s_axi_rid, s_axi_rlast, s_axi_bresp, s_axi_rresp, r_addr[3:0]};

endmodule

`default_nettype wire

// File: tb/tb_serial_axi_bridge.sv
// ============================================================================
// Module : tb_serial_axi_bridge -- directed bench with an AXI slave model and
//          expected-transaction queues for serial_axi_bridge.    Revision 1.0
// ============================================================================
`default_nettype none

module tb_serial_axi_bridge;

`ifdef SERIAL_AXI_BRIDGE_STATUS_EN
    localparam bit STATUS_EN = 1'b1;
`else
    localparam bit STATUS_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         sys_rst;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [3:0]   awid, arid, bid, rid;
    logic [27:0]  awaddr, araddr;
    logic [7:0]   awlen, arlen;
    logic [2:0]   awsize, arsize, awprot, arprot;
    logic [1:0]   awburst, arburst, bresp, rresp;
    logic         awlock, arlock;
    logic [3:0]   awcache, arcache, awqos, arqos;
    logic         awvalid, awready, wlast, wvalid, wready, bready, bvalid;
    logic         arvalid, arready, rready, rlast, rvalid;
    logic [127:0] wdata, rdata;
    logic [15:0]  wstrb;

    int checks   = 0;
    int failures = 0;

    logic [27:0]  exp_aw[$];
    logic [27:0]  exp_ar[$];
    logic [127:0] exp_w[$];
    logic [7:0]   exp_tx[$];
    logic [127:0] mem [logic [27:0]];

    int       aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0] b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
    bit       tx_toggle = 1'b0;

    always #5 clk = ~clk;

    serial_axi_bridge dut (
        .clk(clk), .sys_rst(sys_rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst), .s_axi_awlock(awlock), .s_axi_awcache(awcache),
        .s_axi_awprot(awprot), .s_axi_awqos(awqos), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
        .s_axi_wready(wready),
        .s_axi_bready(bready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst), .s_axi_arlock(arlock), .s_axi_arcache(arcache),
        .s_axi_arprot(arprot), .s_axi_arqos(arqos), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rready(rready), .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .s_axi_rlast(rlast), .s_axi_rvalid(rvalid)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pattern(input logic [27:0] a);
        logic [127:0] p;
        for (int i = 0; i < 16; i++) p[8*i +: 8] = a[11:4] ^ 8'(8'h30 + i);
        return p;
    endfunction

    task automatic push_ack(input logic [1:0] r);
        exp_tx.push_back(8'h4B);
        if (STATUS_EN) exp_tx.push_back({6'b0, r});
    endtask

    task automatic push_read(input logic [127:0] d, input logic [1:0] r);
        for (int i = 0; i < 16; i++) exp_tx.push_back(d[8*i +: 8]);
        if (STATUS_EN) exp_tx.push_back({6'b0, r});
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rx_accept", 128'(rx_ready), 128'(1'b1));
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] a, input logic [127:0] d);
        send_byte(op);
        for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
        if (op == 8'h57) for (int i = 0; i < 16; i++) send_byte(d[8*i +: 8]);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_aw.size() + exp_w.size() + exp_ar.size() + exp_tx.size()) != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 128'(n < 1000), 128'(1'b1));
        repeat (2) @(negedge clk);
    endtask

    // AXI slave and tx sink, evaluated once per negedge.
    initial begin : slave
        int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        bit aw_got, w_got, b_pend, b_hs, r_pend, r_hs, rx_chk, held_v;
        logic [7:0]   held;
        logic [27:0]  last_aw, r_addr_q;
        logic [127:0] last_w;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; rid = 0; rlast = 0; tx_ready = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; b_pend = 0; b_hs = 0; r_pend = 0; r_hs = 0; rx_chk = 0; held_v = 0;
        held = 0; last_aw = 0; last_w = 0; r_addr_q = 0;
        forever begin
            @(negedge clk);
            if (sys_rst) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; tx_ready = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                aw_got = 0; w_got = 0; b_pend = 0; b_hs = 0; r_pend = 0; r_hs = 0;
                rx_chk = 0; held_v = 0;
            end else begin
                if (b_hs) begin
                    check("tx_after_b", 128'(tx_valid), 128'(1'b1));
                    bvalid = 0; b_hs = 0;
                end
                if (r_hs) begin
                    check("tx_after_r", 128'(tx_valid), 128'(1'b1));
                    rvalid = 0; r_hs = 0;
                end
                if (rx_chk) begin
                    check("rx_ready_after_resp", 128'(rx_ready), 128'(1'b1));
                    rx_chk = 0;
                end
                if (held_v) begin
                    check("tx_hold", 128'({tx_valid, tx_data}), 128'({1'b1, held}));
                    held_v = 0;
                end
                // B channel
                if (b_pend) begin
                    if (b_cnt >= b_delay) begin
                        bvalid = 1; bresp = b_resp_cfg; b_pend = 0;
                    end else b_cnt++;
                end
                if (bvalid && bready) b_hs = 1;
                // R channel
                if (r_pend) begin
                    if (r_cnt >= r_delay) begin
                        rvalid = 1; rresp = r_resp_cfg; rlast = 1;
                        rdata  = mem.exists(r_addr_q) ? mem[r_addr_q] : pattern(r_addr_q);
                        r_pend = 0;
                    end else r_cnt++;
                end
                if (rvalid && rready) r_hs = 1;
                // AW channel
                if (awvalid) begin
                    if (!awready) begin
                        if (aw_cnt >= aw_delay) begin
                            awready = 1; aw_got = 1; last_aw = awaddr;
                            check("aw_expected", 128'(exp_aw.size() != 0), 128'(1'b1));
                            if (exp_aw.size() != 0) check("awaddr", 128'(awaddr), 128'(exp_aw.pop_front()));
                            check("aw_attr", 128'({awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos}),
                                  128'({4'd0, 8'd0, 3'b100, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0}));
                        end else aw_cnt++;
                    end
                end else begin
                    awready = 0; aw_cnt = 0;
                end
                // W channel
                if (wvalid) begin
                    if (!wready) begin
                        if (w_cnt >= w_delay) begin
                            wready = 1; w_got = 1; last_w = wdata;
                            check("w_expected", 128'(exp_w.size() != 0), 128'(1'b1));
                            if (exp_w.size() != 0) check("wdata", wdata, exp_w.pop_front());
                            check("w_attr", 128'({wstrb, wlast}), 128'({16'hFFFF, 1'b1}));
                        end else w_cnt++;
                    end
                end else begin
                    wready = 0; w_cnt = 0;
                end
                if (aw_got && w_got) begin
                    mem[last_aw] = last_w;
                    b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0;
                end
                // AR channel
                if (arvalid) begin
                    if (!arready) begin
                        if (ar_cnt >= ar_delay) begin
                            arready = 1; r_pend = 1; r_cnt = 0; r_addr_q = araddr;
                            check("ar_expected", 128'(exp_ar.size() != 0), 128'(1'b1));
                            if (exp_ar.size() != 0) check("araddr", 128'(araddr), 128'(exp_ar.pop_front()));
                            check("ar_attr", 128'({arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos}),
                                  128'({4'd0, 8'd0, 3'b100, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0}));
                        end else ar_cnt++;
                    end
                end else begin
                    arready = 0; ar_cnt = 0;
                end
                // TX sink
                tx_ready = tx_toggle ? ~tx_ready : 1'b1;
                if (tx_valid && tx_ready) begin
                    check("tx_expected", 128'(exp_tx.size() != 0), 128'(1'b1));
                    if (exp_tx.size() != 0) begin
                        check("tx_byte", 128'(tx_data), 128'(exp_tx.pop_front()));
                        if (exp_tx.size() == 0) rx_chk = 1;
                    end
                end else if (tx_valid) begin
                    held = tx_data; held_v = 1;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: observed no finish expected finish before 500000ns");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [127:0] d1, d4, d6, d7;
        int n;
        sys_rst  = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        d1 = 128'h0F0E0D0C0B0A09080706050403020100;
        d4 = {$urandom, $urandom, $urandom, $urandom};
        d6 = {$urandom, $urandom, $urandom, $urandom};
        d7 = {$urandom, $urandom, $urandom, $urandom};
        repeat (3) @(negedge clk);
        check("rst_rx_ready", 128'(rx_ready), 128'(1'b1));
        check("rst_valids", 128'({tx_valid, awvalid, wvalid, wlast, arvalid, bready, rready}), 128'(0));
        check("rst_regs", {tx_data, awaddr, araddr, wdata[63:0]}, 128'(0));
        sys_rst = 1'b0;
        @(negedge clk);

        // Write then read back
        exp_aw.push_back(28'h0000120); exp_w.push_back(d1); push_ack(2'b00);
        send_frame(8'h57, 32'h00000120, d1);
        check("aw_w_at_n1", 128'({awvalid, wvalid, wlast}), 128'(3'b111));
        wait_done();
        exp_ar.push_back(28'h0000120); push_read(d1, 2'b00);
        send_frame(8'h52, 32'h00000120, '0);
        check("ar_at_n1", 128'(arvalid), 128'(1'b1));
        wait_done();

        // Unaligned address, upper bits dropped
        exp_ar.push_back(28'hFFFFF20); push_read(pattern(28'hFFFFF20), 2'b00);
        send_frame(8'h52, 32'h0FFFFF2B, '0);
        wait_done();

        // Invalid opcode is dropped
        send_byte(8'h41);
        check("bad_op_idle", 128'({rx_ready, arvalid, awvalid}), 128'(3'b100));
        exp_ar.push_back(28'h0000300); push_read(pattern(28'h0000300), 2'b00);
        send_frame(8'h52, 32'h00000305, '0);
        wait_done();

        // Independent AW/W handshakes with a throttled tx sink
        w_delay = 3; tx_toggle = 1'b1;
        exp_aw.push_back(28'h0000340); exp_w.push_back(d4); push_ack(2'b00);
        send_frame(8'h57, 32'h00000340, d4);
        check("indep_n1", 128'({awvalid, wvalid}), 128'(2'b11));
        @(negedge clk);
        check("indep_n2", 128'({awvalid, wvalid, wlast}), 128'(3'b011));
        @(negedge clk);
        check("indep_n3", 128'({awvalid, wvalid, wlast}), 128'(3'b011));
        wait_done();
        exp_ar.push_back(28'h0000340); push_read(d4, 2'b00);
        send_frame(8'h52, 32'h00000340, '0);
        wait_done();
        w_delay = 0; tx_toggle = 1'b0;

        // Reset mid-frame
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
        sys_rst = 1'b1;
        #1;
        check("rst_mid_frame", 128'({rx_ready, awvalid, wvalid, arvalid, bready, rready, tx_valid}), 128'(7'b1000000));
        repeat (2) @(negedge clk);
        sys_rst = 1'b0;
        @(negedge clk);

        // Reset during the R wait
        r_delay = 100000;
        exp_ar.push_back(28'h0000500);
        send_frame(8'h52, 32'h00000500, '0);
        n = 0;
        while (!rready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rready_wait", 128'(rready), 128'(1'b1));
        sys_rst = 1'b1;
        #1;
        check("rst_in_r", 128'({rx_ready, awvalid, wvalid, arvalid, bready, rready, tx_valid}), 128'(7'b1000000));
        repeat (2) @(negedge clk);
        sys_rst = 1'b0; r_delay = 0;
        @(negedge clk);
        exp_aw.push_back(28'h0000600); exp_w.push_back(d6); push_ack(2'b00);
        send_frame(8'h57, 32'h00000600, d6);
        wait_done();
        exp_ar.push_back(28'h0000600); push_read(d6, 2'b00);
        send_frame(8'h52, 32'h00000600, '0);
        wait_done();

        // Error response on write, OKAY on read
        b_resp_cfg = 2'b10;
        exp_aw.push_back(28'h0000700); exp_w.push_back(d7); push_ack(2'b10);
        send_frame(8'h57, 32'h00000700, d7);
        wait_done();
        b_resp_cfg = 2'b00;
        exp_ar.push_back(28'h0000700); push_read(d7, 2'b00);
        send_frame(8'h52, 32'h00000700, '0);
        wait_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_axi_bridge.md
# serial_axi_bridge

Command bridge between the UART byte stream (`serial_interface`) and the AXI4 slave port of the DRAM controller wrapper. It parses byte-framed read/write commands from the host, issues single-beat 128-bit AXI transactions, and streams the response bytes back to the UART transmitter. It replaces ad-hoc switch/button-driven AXI strobing in the board top level.

## Interface

Parameters:

- `ADDR_WIDTH`, default 28: AXI address width.
- `DATA_WIDTH`, default 128: AXI data width. Byte count `NBYTES = DATA_WIDTH/8`.
- `ID_WIDTH`, default 4: AXI ID width. All IDs are driven 0.

Ports (one clock; reset is asynchronous and active-high):

- `clk` in 1: single clock for all logic.
- `sys_rst` in 1: asynchronous, active-high reset.
- `rx_data` in 8: command byte from the UART receiver.
- `rx_valid` in 1 / `rx_ready` out 1: command byte handshake.
- `tx_data` out 8: response byte to the UART transmitter.
- `tx_valid` out 1 / `tx_ready` in 1: response byte handshake.
- `s_axi_aw*` out: `awid`, `awaddr[ADDR_WIDTH]`, `awlen`=0, `awsize`=3'b100, `awburst`=INCR, `awlock`/`awcache`/`awprot`/`awqos`=0, `awvalid`; plus `awready` in.
- `s_axi_w*` out: `wdata[DATA_WIDTH]`, `wstrb` all ones, `wlast`, `wvalid`; plus `wready` in.
- `s_axi_b*`: `bready` out; `bid`, `bresp[2]`, `bvalid` in.
- `s_axi_ar*` out: same constants as AW, plus `araddr` and `arvalid`; `arready` in.
- `s_axi_r*`: `rready` out; `rid`, `rdata[DATA_WIDTH]`, `rresp[2]`, `rlast`, `rvalid` in.

## Operation

- **Frame format:** opcode byte, then 4 address bytes (big-endian), then for writes only `NBYTES` data bytes. The first data byte goes to `wdata[7:0]`.
- **Opcodes:** 0x57 ('W') is write; 0x52 ('R') is read. Any other opcode is consumed and dropped; the FSM stays in IDLE.
- **Address:** low `ADDR_WIDTH` bits of the 32-bit assembled value, with `addr[3:0]` forced to 0 (16-byte alignment).
- **FSM states:**
  - IDLE → ADDR on a valid opcode.
  - ADDR: 4 bytes, then → WDATA (write) or AR (read).
  - WDATA: `NBYTES` bytes, then → AW.
  - AW: drives `awvalid` and `wvalid` together, each held independently until its own handshake. `wlast` equals `wvalid`. When both are done → B.
  - B: `bready`=1; on `bvalid` → RESP with the 1-byte response 0x4B ('K').
  - AR: `arvalid` held until `arready` → R.
  - R: `rready`=1; on `rvalid`, capture `rdata` → RESP with the `NBYTES` response, `rdata[7:0]` first.
  - RESP: serialize bytes; after the last `tx` handshake → IDLE.
- **`rx_ready`:** 1 only in IDLE, ADDR and WDATA.
- **Ignored inputs:** `rlast`, `rid`, `bid`.
- **Reset:** `sys_rst` at any point, including mid-frame or mid-AXI, returns to IDLE and discards partial frames. Outputs take their reset values immediately.
- **Reset values:** `tx_valid`, `awvalid`, `wvalid`, `wlast`, `arvalid`, `bready`, `rready` = 0; `tx_data`, address and data registers = 0; `rx_ready` = 1 (IDLE).

## Timing

- At most one `rx` byte accepted per cycle; back-to-back bytes are accepted with no bubbles.
- Last frame byte accepted at cycle N → `awvalid`/`wvalid` (or `arvalid`) high at N+1.
- Each valid is deasserted the cycle after its handshake. A same-cycle `awready` and `wready` completes both at once.
- `bready`/`rready` are high from the cycle after entering B/R; the handshake completes on the first `bvalid`/`rvalid` cycle.
- B/R handshake at cycle M → `tx_valid` with the first byte at M+1.
- `tx_data` advances on the handshake edge, giving 1 byte/cycle while `tx_ready` is held high. `tx_data` is stable while `tx_valid && !tx_ready`.
- Last `tx` handshake at cycle K → IDLE and `rx_ready`=1 at K+1.

## Configuration

- **`SERIAL_AXI_BRIDGE_STATUS_EN` defined:** RESP appends one status byte `{6'b0, resp}` after the normal response, using the captured `bresp`/`rresp`. Responses are 2 bytes for writes and `NBYTES+1` for reads.
- **Undefined:** `bresp`/`rresp` are ignored; response lengths are 1 and `NBYTES`.

## Structure

- **Package `serial_axi_pkg`:**
  - opcode constants `OP_WRITE`/`OP_READ`;
  - `ACK_BYTE` (0x4B);
  - state enum typedef `bridge_state_t`;
  - AXI constants (`AXSIZE_16B`, `BURST_INCR`).
- **Sub-module `serial_axi_resp_ser`:** loads up to `NBYTES+1` bytes plus a length and serializes them onto `tx_*`, with a `done` pulse on the final handshake.

## Test plan

1. **Write then read back:** 'W', 00 00 01 20, bytes 00..0F; slave completes with OKAY → AW addr 0x0000120, `wdata`=0x0F0E…0100, `tx` 0x4B. Then 'R' 00 00 01 20 → `araddr` 0x0000120, `tx` 00,01,…,0F in order.
2. **Unaligned address:** 'R' 0F FF FF 2B → `araddr` 0xFFFFF20 (bits 31:28 dropped, `[3:0]` zeroed).
3. **Invalid opcode:** 0x41 then 'R'… → 0x41 dropped with no AXI activity; the following read executes normally.
4. **Independent channel handshakes:** `awready` 3 cycles before `wready`, with `tx_ready` toggling 1/0 → `awvalid` drops after its handshake while `wvalid` holds; each `tx` byte holds until accepted.
5. **Reset mid-operation:** `sys_rst` asserted after 2 address bytes, and again during the R wait → all valids 0 immediately, `rx_ready`=1; the next full frame is processed correctly.
6. **Status byte (with `SERIAL_AXI_BRIDGE_STATUS_EN`):** write answered with `bresp`=2'b10 → `tx` 0x4B, 0x02. Read answered with OKAY → 16 data bytes then 0x00.
